ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. It takes an M-extension
// op from the ID/EX register, holds the pipeline through stall_out while it
// iterates, and then presents a one-cycle result with a write-enable toward
// EX/MEM.
//
// Ports:
//   clk           pipeline clock, rising edge
//   reset         synchronous active-high reset
//   flush         kills an in-flight op (branch mispredict)
//   start         ID/EX holds a valid M-extension op
//   op            funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   operand_a/b   rs1/rs2 values after forwarding
//   rd_in         destination register of the incoming op
//   stall_out     freezes PC, IF/ID and ID/EX
//   done          result valid this cycle
//   result        mul/div result, holds its value between completions
//   rd_out        destination of the completed op
//   regwrite_out  same as done
//
// State table:
//   state      | meaning
//   ST_IDLE    | waiting for start; divide fast paths resolve here
//   ST_MUL_RUN | shift-add multiply, one multiplier bit per cycle
//   ST_DIV_RUN | restoring divide, one quotient bit per cycle
//   ST_DONE    | result and rd_out valid for one cycle
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            stall_out,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            regwrite_out
);

    localparam int CW = $clog2(ITER);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_RUN,
        ST_DIV_RUN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_res_q;   // product / quotient needs negation
    logic              neg_rem_q;   // remainder follows dividend sign
    logic [CW-1:0]     counter_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quot_q;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    // Incoming operand decode
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, div_ovf, fast_path;
    logic [XLEN-1:0] fast_result;

    // MUL is treated as unsigned: the low half of the product is sign-agnostic.
    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg    = a_signed & operand_a[XLEN-1];
    assign b_neg    = b_signed & operand_b[XLEN-1];
    assign abs_a    = a_neg ? -operand_a : operand_a;
    assign abs_b    = b_neg ? -operand_b : operand_b;

    assign div_by_zero = (operand_b == '0);
    assign div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                         (operand_a == INT_MIN) && (operand_b == '1);
    assign fast_path   = op[2] && (div_by_zero || div_ovf);

    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign fast_result = div_by_zero ? (op[1] ? operand_a : '1)
                                     : (op[1] ? '0 : INT_MIN);

    // Multiply step and final selection
    logic [2*XLEN-1:0] acc_step, prod_fixed;
    logic [XLEN-1:0]   mul_result;

    assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod_fixed = neg_res_q ? -acc_step : acc_step;
    assign mul_result = (op_q[1:0] == 2'b00) ? prod_fixed[XLEN-1:0]
                                             : prod_fixed[2*XLEN-1:XLEN];

    // Restoring divide step: bring in the next dividend bit, try subtracting.
    logic [XLEN:0]   partial, diff;
    logic [XLEN-1:0] rem_step, quot_step, quot_fixed, rem_fixed, div_result;

    assign partial    = {rem_q, quot_q[XLEN-1]};
    assign diff       = partial - {1'b0, divisor_q};
    assign rem_step   = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_step  = {quot_q[XLEN-2:0], ~diff[XLEN]};
    assign quot_fixed = neg_res_q ? -quot_step : quot_step;
    assign rem_fixed  = neg_rem_q ? -rem_step : rem_step;
    assign div_result = op_q[1] ? rem_fixed : quot_fixed;

    logic last_iter;
    assign last_iter = (counter_q == CW'(ITER - 1));

    // FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (fast_path) begin
                        state_d = ST_DONE;
                    end else if (op[2]) begin
                        state_d = ST_DIV_RUN;
                    end else begin
                        state_d = ST_MUL_RUN;
                    end
                end
            end
            ST_MUL_RUN: if (last_iter) state_d = ST_DONE;
            ST_DIV_RUN: if (last_iter) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath. A flush freezes everything so a killed op never reaches
    // result/rd_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            counter_q <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        rd_q      <= rd_in;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        counter_q <= '0;
                        acc_q     <= '0;
                        mcand_q   <= {{XLEN{1'b0}}, abs_a};
                        mplier_q  <= abs_b;
                        rem_q     <= '0;
                        quot_q    <= abs_a;
                        divisor_q <= abs_b;
                        if (fast_path) begin
                            result_q <= fast_result;
                            rd_out_q <= rd_in;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    acc_q     <= acc_step;
                    mcand_q   <= {mcand_q[2*XLEN-2:0], 1'b0};
                    mplier_q  <= {1'b0, mplier_q[XLEN-1:1]};
                    counter_q <= counter_q + CW'(1);
                    if (last_iter) begin
                        result_q <= mul_result;
                        rd_out_q <= rd_q;
                    end
                end
                ST_DIV_RUN: begin
                    rem_q     <= rem_step;
                    quot_q    <= quot_step;
                    counter_q <= counter_q + CW'(1);
                    if (last_iter) begin
                        result_q <= div_result;
                        rd_out_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done         = (state_q == ST_DONE);
    assign regwrite_out = done;
    assign stall_out    = !reset && (((state_q == ST_IDLE) && start) ||
                                     (state_q == ST_MUL_RUN) ||
                                     (state_q == ST_DIV_RUN));
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed table vectors, hand-written flush and
// reset sequences, and randomized ops checked against an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, start;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        stall_out, done, regwrite_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .stall_out    (stall_out),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .regwrite_out (regwrite_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint p;
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && (o == 3'd4 || o == 3'd6);
        if (o[2] && (b == 0 || ovf)) return 1;
        return 33;
    endfunction

    // Entered just after a rising edge with the unit idle; leaves it idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                          input string tag);
        int done_cyc = -1;
        bit stall_ok = 1'b1;
        start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = rd;
        #1;
        check({tag, " stall_at_accept"}, 32'(stall_out), 32'd1);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (done) begin
                done_cyc = c;
                break;
            end
            if (stall_out !== 1'b1) stall_ok = 1'b0;
            // ID/EX keeps start high; operand changes must not matter
            op = 3'($urandom); operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
        end
        check({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
        check({tag, " stall_while_busy"}, 32'(stall_ok), 32'd1);
        if (done_cyc > 0) begin
            check({tag, " result"}, result, exp_res);
            check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
            check({tag, " regwrite"}, 32'(regwrite_out), 32'd1);
            check({tag, " stall_in_done"}, 32'(stall_out), 32'd0);
        end
        start = 1'b0;
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " result_hold"}, result, exp_res);
        last_res = exp_res;
        last_rd  = rd;
    endtask

    initial begin
        int   dc;
        bit   ok;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        tbl.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33});
        tbl.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33});
        tbl.push_back('{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        33});
        tbl.push_back('{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         33});
        tbl.push_back('{3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1});
        tbl.push_back('{3'd7, 32'd5,         32'd0,         5'd14, 32'd5,         1});
        tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1});
        tbl.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFFF, 1});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9, 1});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd19, 32'd3,         33});
        tbl.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd20, 32'd1,         33});
        tbl.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd21, 32'h4000_0000, 33});
        tbl.push_back('{3'd0, 32'h1234_5678, 32'h0000_0010, 5'd22, 32'h2345_6780, 33});

        // Reset with start held high: outputs idle, stall forced low
        reset = 1'b1; flush = 1'b0; start = 1'b1; op = 3'd0;
        operand_a = 32'd3; operand_b = 32'd4; rd_in = 5'd1;
        repeat (3) step();
        check("reset stall", 32'(stall_out), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset regwrite", 32'(regwrite_out), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        start = 1'b0; reset = 1'b0;
        step();
        check("idle done", 32'(done), 32'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat,
                   $sformatf("tbl%0d", i));
        end

        // Flush in the middle of a DIV, then a MUL accepted right after
        start = 1'b1; op = 3'd4; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd9;
        #1;
        ok = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (done !== 1'b0 || stall_out !== 1'b1) ok = 1'b0;
        end
        check("flush pre stall", 32'(ok), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush stall", 32'(stall_out), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result hold", result, last_res);
        check("flush rd hold", 32'(rd_out), 32'(last_rd));
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFEB, 33, "after_flush");

        // Flush during DONE: done still high that cycle, low the next
        start = 1'b1; op = 3'd5; operand_a = 32'd5; operand_b = 32'd0; rd_in = 5'd3;
        step();
        check("flush_done done", 32'(done), 32'd1);
        check("flush_done result", result, 32'hFFFF_FFFF);
        flush = 1'b1;
        step();
        check("flush_done after", 32'(done), 32'd0);
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush_done stall", 32'(stall_out), 32'd0);

        // Flush with start in IDLE: not accepted
        start = 1'b1; flush = 1'b1; op = 3'd7; operand_a = 32'd9; operand_b = 32'd0; rd_in = 5'd4;
        step();
        check("flush_start done", 32'(done), 32'd0);
        flush = 1'b0; start = 1'b0;
        step();
        check("flush_start later", 32'(done), 32'd0);
        check("flush_start result", result, 32'hFFFF_FFFF);
        last_res = 32'hFFFF_FFFF;

        // Reset in the middle of a MUL, start held high throughout
        start = 1'b1; op = 3'd0; operand_a = 32'd7; operand_b = 32'hFFFF_FFFD; rd_in = 5'd5;
        #1;
        ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done !== 1'b0) ok = 1'b0;
        end
        check("rst_mid no done", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid stall", 32'(stall_out), 32'd0);
        step();
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid regwrite", 32'(regwrite_out), 32'd0);
        check("rst_mid result", result, 32'd0);
        check("rst_mid rd_out", 32'(rd_out), 32'd0);
        check("rst_mid stall2", 32'(stall_out), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid accept stall", 32'(stall_out), 32'd1);
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (done) begin
                dc = c;
                break;
            end
        end
        check("rst_mid latency", 32'(dc), 32'd33);
        check("rst_mid result2", result, 32'hFFFF_FFEB);
        check("rst_mid rd2", 32'(rd_out), 32'd5);
        start = 1'b0;
        step();

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 255);
                default: ;
            endcase
            run_op(ro, ra, rb, 5'($urandom), model(ro, ra, rb), model_lat(ro, ra, rb),
                   $sformatf("rand%0d op%0d", i, ro));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
